edit_field_sequencer: RTL and testbench



---
 rtl/edit_field_sequencer_pkg.sv | 35 +++
 rtl/edit_field_sequencer_if.sv | 13 +
 rtl/edit_field_sequencer_field_wrap_step.sv | 22 ++
 rtl/edit_field_sequencer.sv | 176 +++++++++++++++++
 tb/tb_edit_field_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/edit_field_sequencer_pkg.sv
// Shared types and tables for the RTC field editor: FSM states, field indices,
// per-field wrap limits, reset values and the BCD helper used by the commit path.
package edit_field_pkg;

  localparam int FIELDS = 6;
  localparam int VW     = 7;
  localparam int SW     = 3;

  typedef logic [VW-1:0] field_t;

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    COMMIT
  } state_t;

  typedef enum logic [SW-1:0] {
    F_SEC   = 3'd0,
    F_MIN   = 3'd1,
    F_HOUR  = 3'd2,
    F_DAY   = 3'd3,
    F_MONTH = 3'd4,
    F_YEAR  = 3'd5
  } field_idx_t;

  localparam field_t FIELD_MIN [FIELDS] = '{7'd0, 7'd0, 7'd0, 7'd1, 7'd1, 7'd0};
  localparam field_t FIELD_MAX [FIELDS] = '{7'd59, 7'd59, 7'd23, 7'd31, 7'd12, 7'd99};
  localparam field_t FIELD_RESET [FIELDS] = '{7'd0, 7'd0, 7'd0, 7'd1, 7'd1, 7'd0};

  // Values never exceed 99, so both digits fit in a nibble.
  function automatic logic [7:0] to_bcd(input field_t v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/edit_field_sequencer_if.sv
// Commit write port toward the RTC register writer: one word per accepted req/ack.
interface edit_field_sequencer_if;
  import edit_field_pkg::*;

  logic          wr_req;
  logic [SW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);

endinterface

// File: rtl/edit_field_sequencer_field_wrap_step.sv
// Single up/down step of a field value with wrap between its min and max limits.
module field_wrap_step
  import edit_field_pkg::*;
(
  input  field_t value,
  input  field_t lo,
  input  field_t hi,
  input  logic   up,
  input  logic   down,
  output field_t next_value
);

  always_comb begin
    next_value = value;
    if (up) begin
      next_value = (value == hi) ? lo : value + 7'd1;
    end else if (down) begin
      next_value = (value == lo) ? hi : value - 7'd1;
    end
  end

endmodule

// File: rtl/edit_field_sequencer.sv
// Button-driven editor for the six RTC fields with cancel shadow and commit handshake.
// Optional BCD_OUT_EN: commit words carry BCD instead of zero-extended binary.
module edit_field_sequencer
  import edit_field_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  edit_btn,
  input  logic                  cancel,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_right,
  input  logic                  btn_left,
  edit_field_sequencer_if.master wr,
  output logic                  edit_active,
  output logic [SW-1:0]         field_sel,
  output logic [VW-1:0]         field_val,
  output logic                  busy
);

  localparam int B_DOWN   = 0;
  localparam int B_UP     = 1;
  localparam int B_LEFT   = 2;
  localparam int B_RIGHT  = 3;
  localparam int B_EDIT   = 4;
  localparam int B_CANCEL = 5;
  localparam int NBTN     = 6;

  state_t        state_reg, state_next;
  logic [SW-1:0] field_sel_reg, field_sel_next;
  field_t        field_reg [FIELDS];
  field_t        field_next [FIELDS];
  field_t        shadow_reg [FIELDS];
  field_t        shadow_next [FIELDS];
  logic [NBTN-1:0] prev_reg;
  logic            wr_req_reg, wr_req_next;
  logic [SW-1:0]   wr_addr_reg, wr_addr_next;
  logic [7:0]      wr_data_reg, wr_data_next;

  logic [NBTN-1:0] btn_vec, edge_vec;
  logic act_cancel, act_edit, act_right, act_left, step_up, step_down;
  logic [FIELDS-1:0] sel_hot;
  field_t sel_val, sel_lo, sel_hi, step_val, word_val;

  function automatic logic [7:0] encode_word(input field_t v);
`ifdef BCD_OUT_EN
    return to_bcd(v);
`else
    return {1'b0, v};
`endif
  endfunction

  assign btn_vec  = {cancel, edit_btn, btn_right, btn_left, btn_up, btn_down};
  assign edge_vec = btn_vec & ~prev_reg;

  // Only the highest-priority edge in a cycle acts; lower ones are dropped.
  assign act_cancel = edge_vec[B_CANCEL];
  assign act_edit   = edge_vec[B_EDIT]  & ~edge_vec[B_CANCEL];
  assign act_right  = edge_vec[B_RIGHT] & ~|edge_vec[B_CANCEL:B_EDIT];
  assign act_left   = edge_vec[B_LEFT]  & ~|edge_vec[B_CANCEL:B_RIGHT];
  assign step_up    = (state_reg == EDIT) & edge_vec[B_UP]   & ~|edge_vec[B_CANCEL:B_LEFT];
  assign step_down  = (state_reg == EDIT) & edge_vec[B_DOWN] & ~|edge_vec[B_CANCEL:B_UP];

  generate
    for (genvar gi = 0; gi < FIELDS; gi++) begin : g_sel
      assign sel_hot[gi] = (field_sel_reg == SW'(gi));
    end
  endgenerate

  always_comb begin
    sel_val = '0;
    sel_lo  = '0;
    sel_hi  = '0;
    for (int i = 0; i < FIELDS; i++) begin
      if (sel_hot[i]) begin
        sel_val = field_reg[i];
        sel_lo  = FIELD_MIN[i];
        sel_hi  = FIELD_MAX[i];
      end
    end
  end

  field_wrap_step u_step (
    .value      (sel_val),
    .lo         (sel_lo),
    .hi         (sel_hi),
    .up         (step_up),
    .down       (step_down),
    .next_value (step_val)
  );

  always_comb begin
    state_next     = state_reg;
    field_sel_next = field_sel_reg;
    field_next     = field_reg;
    shadow_next    = shadow_reg;
    wr_req_next    = wr_req_reg;
    wr_addr_next   = wr_addr_reg;
    word_val       = '0;
    case (state_reg)
      IDLE: begin
        if (edge_vec[B_EDIT]) begin
          shadow_next    = field_reg;
          field_sel_next = F_SEC;
          state_next     = EDIT;
        end
      end
      EDIT: begin
        if (act_cancel) begin
          field_next = shadow_reg;
          state_next = IDLE;
        end else if (act_edit) begin
          state_next   = COMMIT;
          wr_req_next  = 1'b1;
          wr_addr_next = F_SEC;
        end else if (act_right) begin
          field_sel_next = (field_sel_reg == F_YEAR) ? F_SEC : field_sel_reg + 3'd1;
        end else if (act_left) begin
          field_sel_next = (field_sel_reg == F_SEC) ? F_YEAR : field_sel_reg - 3'd1;
        end else if (step_up || step_down) begin
          for (int i = 0; i < FIELDS; i++) begin
            if (sel_hot[i]) field_next[i] = step_val;
          end
        end
      end
      COMMIT: begin
        if (wr.wr_ack) begin
          if (wr_addr_reg == F_YEAR) begin
            state_next   = IDLE;
            wr_req_next  = 1'b0;
            wr_addr_next = '0;
          end else begin
            wr_addr_next = wr_addr_reg + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Fields are frozen during COMMIT, so the word stays stable across stalls.
    for (int i = 0; i < FIELDS; i++) begin
      if (wr_addr_next == SW'(i)) word_val = field_reg[i];
    end
    wr_data_next = wr_req_next ? encode_word(word_val) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      field_sel_reg <= '0;
      field_reg     <= FIELD_RESET;
      shadow_reg    <= FIELD_RESET;
      prev_reg      <= '0;
      wr_req_reg    <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      field_sel_reg <= field_sel_next;
      field_reg     <= field_next;
      shadow_reg    <= shadow_next;
      prev_reg      <= btn_vec;
      wr_req_reg    <= wr_req_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
    end
  end

  assign wr.wr_req   = wr_req_reg;
  assign wr.wr_addr  = wr_addr_reg;
  assign wr.wr_data  = wr_data_reg;
  assign edit_active = (state_reg == EDIT);
  assign busy        = (state_reg == COMMIT);
  assign field_sel   = field_sel_reg;
  assign field_val   = sel_val;

endmodule

// File: tb/tb_edit_field_sequencer.sv
// Scoreboard bench for edit_field_sequencer: field model plus queue of expected commit words.
module tb_edit_field_sequencer;

  localparam int B_DOWN   = 0;
  localparam int B_UP     = 1;
  localparam int B_LEFT   = 2;
  localparam int B_RIGHT  = 3;
  localparam int B_EDIT   = 4;
  localparam int B_CANCEL = 5;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } word_t;

  logic clk, rst;
  logic edit_btn, cancel, btn_up, btn_down, btn_right, btn_left;
  logic wr_ack;
  logic edit_active, busy;
  logic [2:0] field_sel;
  logic [6:0] field_val;

  edit_field_sequencer_if wb ();
  assign wb.wr_ack = wr_ack;

  edit_field_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .edit_btn    (edit_btn),
    .cancel      (cancel),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_right   (btn_right),
    .btn_left    (btn_left),
    .wr          (wb),
    .edit_active (edit_active),
    .field_sel   (field_sel),
    .field_val   (field_val),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;
  int lo [6] = '{0, 0, 0, 1, 1, 0};
  int hi [6] = '{59, 59, 23, 31, 12, 99};
  int rst_val [6] = '{0, 0, 0, 1, 1, 0};
  int m_field [6];
  int m_shadow [6];
  int m_sel;
  word_t exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] enc(input int v);
`ifdef BCD_OUT_EN
    return 8'(((v / 10) << 4) | (v % 10));
`else
    return 8'(v);
`endif
  endfunction

  task automatic drive(input int b, input logic v);
    case (b)
      B_DOWN:   btn_down  = v;
      B_UP:     btn_up    = v;
      B_LEFT:   btn_left  = v;
      B_RIGHT:  btn_right = v;
      B_EDIT:   edit_btn  = v;
      default:  cancel    = v;
    endcase
  endtask

  task automatic press(input int b);
    @(negedge clk);
    drive(b, 1'b1);
    @(negedge clk);
    drive(b, 1'b0);
  endtask

  // Navigation/value action in EDIT, with model update and readback.
  task automatic act(input int b);
    press(b);
    case (b)
      B_RIGHT: m_sel = (m_sel == 5) ? 0 : m_sel + 1;
      B_LEFT:  m_sel = (m_sel == 0) ? 5 : m_sel - 1;
      B_UP:    m_field[m_sel] = (m_field[m_sel] == hi[m_sel]) ? lo[m_sel] : m_field[m_sel] + 1;
      default: m_field[m_sel] = (m_field[m_sel] == lo[m_sel]) ? hi[m_sel] : m_field[m_sel] - 1;
    endcase
    check("act_sel", field_sel, m_sel);
    check("act_val", field_val, m_field[m_sel]);
    $display("act btn=%0d sel=%0d val=%0d", b, field_sel, field_val);
  endtask

  task automatic enter_edit();
    press(B_EDIT);
    m_shadow = m_field;
    m_sel = 0;
    check("enter_active", edit_active, 1);
    check("enter_sel", field_sel, 0);
    $display("enter edit sel=%0d val=%0d", field_sel, field_val);
  endtask

  task automatic start_commit();
    for (int i = 0; i < 6; i++) exp_q.push_back('{addr: 3'(i), data: enc(m_field[i])});
    press(B_EDIT);
    check("commit_req", wb.wr_req, 1);
    check("commit_busy", busy, 1);
  endtask

  task automatic run_commit(input int stall, input int abort_at);
    int popped = 0;
    int guard = 0;
    word_t w;
    wr_ack = 1'b0;
    for (int c = 0; c < stall; c++) begin
      cancel = (c < 2);
      check("stall_req", wb.wr_req, 1);
      check("stall_addr", wb.wr_addr, exp_q[0].addr);
      check("stall_data", wb.wr_data, exp_q[0].data);
      @(negedge clk);
    end
    cancel = 1'b0;
    wr_ack = 1'b1;
    while (exp_q.size() > 0 && guard < 40) begin
      if (abort_at >= 0 && popped == abort_at) break;
      if (wb.wr_req === 1'b1) begin
        w = exp_q.pop_front();
        check("word_addr", wb.wr_addr, w.addr);
        check("word_data", wb.wr_data, w.data);
        check("word_busy", busy, 1);
        $display("word %0d addr=%0d data=%02h", popped, wb.wr_addr, wb.wr_data);
        popped++;
      end
      guard++;
      @(negedge clk);
    end
    if (abort_at < 0) begin
      wr_ack = 1'b0;
      check("words_left", exp_q.size(), 0);
      check("done_req", wb.wr_req, 0);
      check("done_busy", busy, 0);
      check("done_active", edit_active, 0);
    end else begin
      check("abort_popped", popped, abort_at);
    end
  endtask

  initial begin
    rst = 1'b1;
    {edit_btn, cancel, btn_up, btn_down, btn_right, btn_left} = '0;
    wr_ack = 1'b0;
    m_field = rst_val;
    m_shadow = rst_val;
    m_sel = 0;
    repeat (3) @(negedge clk);
    check("rst_active", edit_active, 0);
    check("rst_req", wb.wr_req, 0);
    check("rst_busy", busy, 0);
    check("rst_sel", field_sel, 0);
    check("rst_addr", wb.wr_addr, 0);
    check("rst_data", wb.wr_data, 0);
    rst = 1'b0;

    enter_edit();
    for (int i = 0; i < 6; i++) begin
      check("rst_field", field_val, rst_val[i]);
      act(B_RIGHT);
    end

    // sec wrap both ways, no carry into min
    act(B_DOWN); act(B_UP); act(B_DOWN); act(B_UP);
    act(B_DOWN); act(B_UP);
    act(B_RIGHT);
    // month and day wrap
    act(B_LEFT); act(B_LEFT); act(B_LEFT);
    act(B_DOWN); act(B_UP);
    act(B_LEFT);
    act(B_DOWN); act(B_UP); act(B_DOWN);

    // hour 0 -> 5 then cancel restores everything
    act(B_LEFT);
    repeat (5) act(B_UP);
    press(B_CANCEL);
    m_field = m_shadow;
    check("cancel_active", edit_active, 0);
    check("cancel_val", field_val, m_field[m_sel]);
    press(B_UP);
    check("idle_up_ignored", field_val, m_field[m_sel]);
    $display("cancel sel=%0d val=%0d", field_sel, field_val);

    enter_edit();
    act(B_RIGHT); act(B_RIGHT);
    // simultaneous up and right: only the selection moves
    @(negedge clk);
    btn_up = 1'b1; btn_right = 1'b1;
    @(negedge clk);
    btn_up = 1'b0; btn_right = 1'b0;
    m_sel = m_sel + 1;
    check("simul_sel", field_sel, m_sel);
    check("simul_val", field_val, m_field[m_sel]);
    act(B_LEFT);

    // min -> 45, hour -> 7, year -> 97
    act(B_LEFT);
    repeat (15) act(B_DOWN);
    act(B_RIGHT);
    repeat (7) act(B_UP);
    act(B_LEFT); act(B_LEFT); act(B_LEFT);
    repeat (3) act(B_DOWN);

    start_commit();
    run_commit(3, -1);

    // fields unchanged by the commit and by buttons during it
    enter_edit();
    for (int i = 0; i < 6; i++) begin
      check("post_commit_field", field_val, m_field[i]);
      act(B_RIGHT);
    end

    // reset mid-commit, with edit_btn held across reset release
    start_commit();
    run_commit(0, 2);
    rst = 1'b1;
    edit_btn = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    check("rstmid_req", wb.wr_req, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_active", edit_active, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("held_fires", edit_active, 1);
    repeat (2) @(negedge clk);
    check("held_once", edit_active, 1);
    edit_btn = 1'b0;
    m_field = rst_val;
    m_shadow = rst_val;
    m_sel = 0;
    for (int i = 0; i < 6; i++) begin
      check("rstmid_field", field_val, rst_val[i]);
      act(B_RIGHT);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
